// File: rtl/backtrack_controller.sv
// Backtrack controller for a DPLL-style solver.
//
// Sits between the propagation engine, the decision heuristic and an external
// assignment trail. While idle it forwards implications and decisions to the
// trail as push commands. On a conflict it pops forced entries until the most
// recent decision, pops that decision too, then re-pushes the decision's
// variable with the opposite value as a forced assignment. If the trail runs
// empty before a decision is found, the problem is unsatisfiable and the
// controller parks in UNSAT until reset.
//
// Handshake semantics: a transfer on imply_* / decide_* happens on a rising
// edge where valid and ready are both high. Ready is a combinational function
// of the current state and of conflict/imply_valid, never of the matching
// valid. A producer holds valid and its payload stable until the transfer
// completes. The trail applies cmd_assign / cmd_pop on the same edge.
//
// State is exported on dbg_state so that checkers can follow the FSM.

module backtrack_controller #(
    parameter int NUM_VARS = 16,
    localparam int VW = $clog2(NUM_VARS + 1)
) (
    input  logic          clk,
    input  logic          rst,

    // Propagation side
    input  logic          conflict,
    input  logic          imply_valid,
    output logic          imply_ready,
    input  logic [VW-1:0] imply_var,
    input  logic          imply_val,

    // Decision heuristic side
    input  logic          decide_valid,
    output logic          decide_ready,
    input  logic [VW-1:0] decide_var,
    input  logic          decide_val,

    // Trail commands (combinational, sampled by the trail on the next edge)
    output logic          cmd_assign,
    output logic [VW-1:0] assign_var,
    output logic          assign_val,
    output logic          assign_forced,
    output logic          cmd_pop,

    // Combinational view of the trail top
    input  logic [VW-1:0] popped_var,
    input  logic          popped_val,
    input  logic          popped_forced,
    input  logic          stack_empty,

    // Status
    output logic          busy,
    output logic          bt_done,
    output logic          unsat,
    output logic [VW:0]   bt_pop_count,

    // FSM state for observation
    output logic [2:0]    dbg_state
);

    localparam int CW = VW + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_FLIP  = 3'd2,
        S_DONE  = 3'd3,
        S_UNSAT = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [VW-1:0] lat_var_q, lat_var_d;
    logic          lat_val_q, lat_val_d;
    logic [CW-1:0] bt_cnt_q, bt_cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          unsat_q, unsat_d;

    // Saturating increment of the running pop counter.
    always_comb begin
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    // Next-state and datapath update for the backtrack sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_var_d = lat_var_q;
        lat_val_d = lat_val_q;
        bt_cnt_d  = bt_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (conflict) begin
                    state_d = S_POP;
                    cnt_d   = '0;
                end
            end
            S_POP: begin
                if (stack_empty) begin
                    // No decision left to flip: the formula is unsatisfiable.
                    state_d = S_UNSAT;
                end else begin
                    cnt_d = cnt_inc;
                    if (!popped_forced) begin
                        lat_var_d = popped_var;
                        lat_val_d = ~popped_val;
                        state_d   = S_FLIP;
                    end
                end
            end
            S_FLIP: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                bt_cnt_d = cnt_q;
                state_d  = S_IDLE;
            end
            S_UNSAT: begin
                state_d = S_UNSAT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered status flags follow the state being entered.
    always_comb begin
        busy_d  = (state_d == S_POP) || (state_d == S_FLIP) || (state_d == S_DONE);
        done_d  = (state_d == S_DONE);
        unsat_d = (state_d == S_UNSAT);
    end

    // Trail commands and ready outputs; all forced low while in reset.
    always_comb begin
        cmd_assign    = 1'b0;
        cmd_pop       = 1'b0;
        assign_var    = '0;
        assign_val    = 1'b0;
        assign_forced = 1'b0;
        imply_ready   = 1'b0;
        decide_ready  = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    // Conflict beats implication, implication beats decision.
                    if (!conflict) begin
                        imply_ready  = 1'b1;
                        decide_ready = ~imply_valid;
                        if (imply_valid) begin
                            cmd_assign    = 1'b1;
                            assign_var    = imply_var;
                            assign_val    = imply_val;
                            assign_forced = 1'b1;
                        end else if (decide_valid) begin
                            cmd_assign    = 1'b1;
                            assign_var    = decide_var;
                            assign_val    = decide_val;
                            assign_forced = 1'b0;
                        end
                    end
                end
                S_POP: begin
                    cmd_pop = ~stack_empty;
                end
                S_FLIP: begin
                    cmd_assign    = 1'b1;
                    assign_var    = lat_var_q;
                    assign_val    = lat_val_q;
                    assign_forced = 1'b1;
                end
                default: begin
                    cmd_pop = 1'b0;
                end
            endcase
        end
    end

    // Single state register for the FSM and its datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            lat_var_q <= '0;
            lat_val_q <= 1'b0;
            bt_cnt_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            unsat_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_var_q <= lat_var_d;
            lat_val_q <= lat_val_d;
            bt_cnt_q  <= bt_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            unsat_q   <= unsat_d;
        end
    end

    assign busy         = busy_q;
    assign bt_done      = done_q;
    assign unsat        = unsat_q;
    assign bt_pop_count = bt_cnt_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_backtrack_controller.sv
// Bench for backtrack_controller: an array-based trail answers the DUT's
// commands, and an abstract stack model predicts each cycle's outputs.

module tb_backtrack_controller;

    localparam int NV = 16;
    localparam int VW = $clog2(NV + 1);
    localparam int SAT = 63;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          conflict = 1'b0;
    logic          imply_valid = 1'b0, imply_val = 1'b0;
    logic [VW-1:0] imply_var = '0;
    logic          decide_valid = 1'b0, decide_val = 1'b0;
    logic [VW-1:0] decide_var = '0;
    logic          imply_ready, decide_ready;
    logic          cmd_assign, assign_val, assign_forced, cmd_pop;
    logic [VW-1:0] assign_var;
    logic [VW-1:0] popped_var;
    logic          popped_val, popped_forced, stack_empty;
    logic          busy, bt_done, unsat;
    logic [VW:0]   bt_pop_count;
    logic [2:0]    dbg_state;

    backtrack_controller #(.NUM_VARS(NV)) dut (
        .clk(clk), .rst(rst), .conflict(conflict),
        .imply_valid(imply_valid), .imply_ready(imply_ready),
        .imply_var(imply_var), .imply_val(imply_val),
        .decide_valid(decide_valid), .decide_ready(decide_ready),
        .decide_var(decide_var), .decide_val(decide_val),
        .cmd_assign(cmd_assign), .assign_var(assign_var),
        .assign_val(assign_val), .assign_forced(assign_forced),
        .cmd_pop(cmd_pop), .popped_var(popped_var), .popped_val(popped_val),
        .popped_forced(popped_forced), .stack_empty(stack_empty),
        .busy(busy), .bt_done(bt_done), .unsat(unsat),
        .bt_pop_count(bt_pop_count), .dbg_state(dbg_state)
    );

    // ---------------- trail environment ----------------
    logic [VW-1:0] env_var [0:255];
    logic          env_val [0:255];
    logic          env_frc [0:255];
    int            env_sp = 0;

    always @(posedge clk) begin
        if (rst) begin
            env_sp <= 0;
        end else if (cmd_assign && env_sp < 256) begin
            env_var[env_sp] <= assign_var;
            env_val[env_sp] <= assign_val;
            env_frc[env_sp] <= assign_forced;
            env_sp <= env_sp + 1;
        end else if (cmd_pop && env_sp > 0) begin
            env_sp <= env_sp - 1;
        end
    end

    assign stack_empty   = (env_sp == 0);
    assign popped_var    = (env_sp > 0) ? env_var[env_sp-1] : '0;
    assign popped_val    = (env_sp > 0) ? env_val[env_sp-1] : 1'b0;
    assign popped_forced = (env_sp > 0) ? env_frc[env_sp-1] : 1'b0;

    // ---------------- scoreboard / model ----------------
    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];          // expected per-cycle output vectors
    logic [6:0]  ref_trail[$];      // {forced, val, var}
    bit          model_unsat = 0;
    int          exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pk(input logic ca, input logic cp, input logic [VW-1:0] av,
                                       input logic aval, input logic af, input logic bz,
                                       input logic dn, input logic us, input logic ir,
                                       input logic dr);
        pk = {18'd0, ca, cp, av, aval, af, bz, dn, us, ir, dr};
    endfunction

    function automatic logic [31:0] obs();
        obs = pk(cmd_assign, cmd_pop, cmd_assign ? assign_var : '0,
                 cmd_assign & assign_val, cmd_assign & assign_forced,
                 busy, bt_done, unsat, imply_ready, decide_ready);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_inputs(input logic c, input logic iv, input logic [VW-1:0] ivr,
                              input logic ivl, input logic dv, input logic [VW-1:0] dvr,
                              input logic dvl);
        conflict = c; imply_valid = iv; imply_var = ivr; imply_val = ivl;
        decide_valid = dv; decide_var = dvr; decide_val = dvl;
    endtask

    task automatic junk_inputs();
        set_inputs($urandom_range(0, 1), $urandom_range(0, 1), VW'($urandom_range(0, NV)),
                   $urandom_range(0, 1), $urandom_range(0, 1), VW'($urandom_range(0, NV)),
                   $urandom_range(0, 1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        junk_inputs();
        #1;
        chk("rst_cmds", {28'd0, cmd_assign, cmd_pop, imply_ready, decide_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_inputs(0, 0, '0, 0, 0, '0, 0);
        #1;
        chk("rst_count", {26'd0, bt_pop_count}, 32'd0);
        chk("rst_state", obs(), pk(0, 0, '0, 0, 0, 0, 0, 0, 1, 1));
        ref_trail.delete();
        exp_q.delete();
        model_unsat = 0;
    endtask

    // One idle-phase cycle; a conflict also queues the whole backtrack.
    task automatic step_idle(input logic c, input logic iv, input logic [VW-1:0] ivr,
                             input logic ivl, input logic dv, input logic [VW-1:0] dvr,
                             input logic dvl);
        logic [31:0] e;
        logic [6:0]  d;
        int n, k;
        @(negedge clk);
        set_inputs(c, iv, ivr, ivl, dv, dvr, dvl);
        #1;
        if (c) begin
            e = pk(0, 0, '0, 0, 0, 0, 0, 0, 0, 0);
        end else if (iv) begin
            e = pk(1, 0, ivr, ivl, 1, 0, 0, 0, 1, 0);
            ref_trail.push_back({1'b1, ivl, ivr});
        end else if (dv) begin
            e = pk(1, 0, dvr, dvl, 0, 0, 0, 0, 1, 1);
            ref_trail.push_back({1'b0, dvl, dvr});
        end else begin
            e = pk(0, 0, '0, 0, 0, 0, 0, 0, 1, ~iv);
        end
        chk(c ? "conflict_cycle" : "idle_cycle", obs(), e);
        if (c) begin
            n = ref_trail.size();
            k = 0;
            while (k < n && ref_trail[n-1-k][6]) k++;
            for (int i = 0; i < k; i++) exp_q.push_back(pk(0, 1, '0, 0, 0, 1, 0, 0, 0, 0));
            if (k < n) begin
                d = ref_trail[n-1-k];
                exp_q.push_back(pk(0, 1, '0, 0, 0, 1, 0, 0, 0, 0));
                exp_q.push_back(pk(1, 0, d[VW-1:0], ~d[5], 1, 1, 0, 0, 0, 0));
                exp_q.push_back(pk(0, 0, '0, 0, 0, 1, 1, 0, 0, 0));
                for (int i = 0; i <= k; i++) void'(ref_trail.pop_back());
                ref_trail.push_back({1'b1, ~d[5], d[VW-1:0]});
                exp_cnt = (k + 1 > SAT) ? SAT : k + 1;
                model_unsat = 0;
            end else begin
                exp_q.push_back(pk(0, 0, '0, 0, 0, 1, 0, 0, 0, 0));
                ref_trail.delete();
                model_unsat = 1;
            end
        end
    endtask

    task automatic bt_cycle(input string tag);
        @(negedge clk);
        junk_inputs();
        #1;
        chk(tag, obs(), exp_q.pop_front());
    endtask

    // Drain the queued backtrack, then check the landing state.
    task automatic run_backtrack();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 1000) begin
            bt_cycle("bt_cycle");
            guard++;
        end
        if (!model_unsat) begin
            @(negedge clk);
            set_inputs(0, 0, '0, 0, 0, '0, 0);
            #1;
            chk("pop_count", {26'd0, bt_pop_count}, exp_cnt);
            chk("post_bt", obs(), pk(0, 0, '0, 0, 0, 0, 0, 0, 1, 1));
        end else begin
            repeat (4) begin
                @(negedge clk);
                junk_inputs();
                #1;
                chk("unsat_hold", obs(), pk(0, 0, '0, 0, 0, 0, 0, 1, 0, 0));
            end
            do_reset();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        do_reset();

        // Decide 3=1, imply 5=0, imply 7=1, conflict: three pops, flip 3 to 0.
        step_idle(0, 0, '0, 0, 1, 5'd3, 1);
        step_idle(0, 1, 5'd5, 0, 0, '0, 0);
        step_idle(0, 1, 5'd7, 1, 0, '0, 0);
        step_idle(1, 0, '0, 0, 0, '0, 0);
        run_backtrack();

        // Empty trail conflict ends in UNSAT.
        do_reset();
        step_idle(1, 0, '0, 0, 1, 5'd2, 1);
        run_backtrack();

        // Only forced entries: two pops then UNSAT.
        step_idle(0, 1, 5'd1, 1, 0, '0, 0);
        step_idle(0, 1, 5'd2, 0, 0, '0, 0);
        step_idle(1, 0, '0, 0, 0, '0, 0);
        run_backtrack();

        // Implication wins over decision, decision goes next cycle;
        // conflict blocks a pending implication.
        step_idle(0, 1, 5'd4, 1, 1, 5'd9, 0);
        step_idle(0, 0, '0, 0, 1, 5'd9, 0);
        step_idle(1, 1, 5'd6, 1, 0, '0, 0);
        run_backtrack();

        // Reset after the first pop aborts without any flip.
        do_reset();
        step_idle(0, 0, '0, 0, 1, 5'd3, 1);
        step_idle(0, 1, 5'd5, 0, 0, '0, 0);
        step_idle(1, 0, '0, 0, 0, '0, 0);
        bt_cycle("abort_first_pop");
        do_reset();

        // Pop counter saturation: 70 forced entries above one decision.
        step_idle(0, 0, '0, 0, 1, 5'd1, 1);
        for (int i = 0; i < 70; i++) step_idle(0, 1, VW'(i % 17), i[0], 0, '0, 0);
        step_idle(1, 0, '0, 0, 0, '0, 0);
        run_backtrack();

        // Random episodes.
        do_reset();
        for (int ep = 0; ep < 40; ep++) begin
            if (ref_trail.size() > 120) do_reset();
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) begin
                step_idle(0, $urandom_range(0, 3) == 0, VW'($urandom_range(0, NV)),
                          $urandom_range(0, 1), $urandom_range(0, 2) == 0,
                          VW'($urandom_range(0, NV)), $urandom_range(0, 1));
            end
            step_idle(1, $urandom_range(0, 1), VW'($urandom_range(0, NV)), $urandom_range(0, 1),
                      $urandom_range(0, 1), VW'($urandom_range(0, NV)), $urandom_range(0, 1));
            run_backtrack();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/backtrack_controller.md
BACKTRACK_CONTROLLER -- requirements
Module: backtrack_controller

Interface
REQ-001 SHALL have parameter NUM_VARS, default 16, meaning number of solver variables; VW = $clog2(NUM_VARS+1).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port conflict  input  1  pulse from propagation: current assignment is contradictory.
REQ-005 SHALL have ports imply_valid/imply_ready  input/output  1/1  forced-assignment handshake.
REQ-006 SHALL have ports imply_var, imply_val  input  VW, 1  implied variable and value.
REQ-007 SHALL have ports decide_valid/decide_ready  input/output  1/1  decision handshake.
REQ-008 SHALL have ports decide_var, decide_val  input  VW, 1  decided variable and value.
REQ-009 SHALL have ports cmd_assign, assign_var, assign_val, assign_forced  output  1, VW, 1, 1  trail push command.
REQ-010 SHALL have port cmd_pop  output  1  trail pop command.
REQ-011 SHALL have ports popped_var, popped_val, popped_forced, stack_empty  input  VW, 1, 1, 1  combinational trail-top view.
REQ-012 SHALL have ports busy, bt_done, unsat  output  1 each  backtrack active, one-cycle completion pulse, sticky unsatisfiable flag.
REQ-013 SHALL have port bt_pop_count  output  VW+1  number of pops performed by the last backtrack.

Function
REQ-014 SHALL implement FSM states IDLE, POP, FLIP, DONE, UNSAT.
REQ-015 Trail commands SHALL be combinational decodes of state and inputs; the trail samples them at the next edge.
REQ-016 At most one of cmd_assign, cmd_pop SHALL be high in any cycle.
REQ-017 IDLE: conflict=1 SHALL transition to POP, clear the pop counter, and issue no command that cycle.
REQ-018 IDLE, conflict=0: imply_ready=1; imply_valid=1 SHALL drive cmd_assign=1 with imply_var, imply_val, assign_forced=1.
REQ-019 IDLE, conflict=0, imply_valid=0: decide_ready=1; decide_valid=1 SHALL drive cmd_assign=1 with decide_var, decide_val, assign_forced=0.
REQ-020 Implication SHALL win over decision in the same cycle; conflict SHALL win over both; ready outputs SHALL be 0 outside IDLE.
REQ-021 POP with stack_empty=1 SHALL issue no command and go to UNSAT.
REQ-022 POP with popped_forced=1 SHALL assert cmd_pop, increment pop counter, and remain in POP.
REQ-023 POP with popped_forced=0 SHALL assert cmd_pop, increment the counter, latch popped_var and ~popped_val, and go to FLIP.
REQ-024 FLIP SHALL assert cmd_assign with latched var, latched inverted value, assign_forced=1, and go to DONE.
REQ-025 DONE SHALL pulse bt_done=1 for one cycle, load bt_pop_count from the counter, and return to IDLE.
REQ-026 Pop counter SHALL saturate at 2^(VW+1)-1.
REQ-027 busy SHALL be 1 in POP, FLIP, DONE.
REQ-028 UNSAT SHALL hold unsat=1, assert no commands, ignore conflict/imply/decide, and exit only via rst.
REQ-029 conflict asserted outside IDLE SHALL be ignored.

Reset
REQ-030 rst SHALL force IDLE, unsat=0, bt_done=0, bt_pop_count=0, latched var/val=0, with all commands 0 during the reset cycle.
REQ-031 rst mid-backtrack SHALL abort without issuing a FLIP assignment; the trail is reset by its own rst.

Verification
REQ-032 Decide var3=1, imply var5=0, imply var7=1, conflict -> cmd_pop ×3 (var7, var5, var3), cmd_assign var3=0 forced=1, bt_done, bt_pop_count=3.
REQ-033 Empty trail, conflict -> no commands, unsat=1 two cycles later, stays 1 under further conflict/decide until rst.
REQ-034 Only forced entries on trail (imply var1, var2), conflict -> two pops, then unsat=1, no cmd_assign.
REQ-035 imply_valid and decide_valid both 1 in IDLE -> implication pushed forced=1, decide_ready=0; decision accepted next cycle.
REQ-036 conflict with imply_valid=1 -> imply_ready=0, no push, POP entered.
REQ-037 rst asserted in POP after one pop -> next cycle IDLE, busy=0, no cmd_assign issued, unsat=0.
